// File: rtl/slot_pkg.sv
// -----------------------------------------------------------------------------
// slot_pkg
// Shared definitions for the slot-machine round sequencer:
//   - state_e     : round FSM states
//   - BET_*       : bet values selectable by the bet switches
//   - bet_code_t  : one-hot bet code {b100,b50,b10,b1}
//   - BAL_W       : width of the bank balance
//   - fold_digit  : maps an LFSR nibble onto a reel digit 0..9
// -----------------------------------------------------------------------------
package slot_pkg;

    localparam int BAL_W = 27;
    localparam int AMT_W = 7;

    localparam logic [AMT_W-1:0] BET_1   = 7'd1;
    localparam logic [AMT_W-1:0] BET_10  = 7'd10;
    localparam logic [AMT_W-1:0] BET_50  = 7'd50;
    localparam logic [AMT_W-1:0] BET_100 = 7'd100;

    // One-hot bet code, bit order {b100, b50, b10, b1}.
    typedef logic [3:0] bet_code_t;

    localparam bet_code_t CODE_NONE = 4'b0000;
    localparam bet_code_t CODE_1    = 4'b0001;
    localparam bet_code_t CODE_10   = 4'b0010;
    localparam bet_code_t CODE_50   = 4'b0100;
    localparam bet_code_t CODE_100  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SPIN   = 3'd1,
        ST_STOP   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_HOLD   = 3'd4
    } state_e;

    // Nibbles 10..15 wrap to 0..5 so every reel shows a decimal digit.
    function automatic logic [3:0] fold_digit(input logic [3:0] nib);
        return (nib >= 4'd10) ? (nib - 4'd10) : nib;
    endfunction

endpackage

// File: rtl/slot_lfsr16.sv
// -----------------------------------------------------------------------------
// slot_lfsr16
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10).
// Advances on every clock; reloads the seed while rst is high.
// Ports:
//   clk  : system clock
//   rst  : synchronous active-high reset, loads seed
//   seed : reset value, must be nonzero
//   q    : current LFSR state
// -----------------------------------------------------------------------------
module slot_lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {q_q[14:0], q_q[15] ^ q_q[13] ^ q_q[12] ^ q_q[10]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/slot_round_ctrl.sv
// -----------------------------------------------------------------------------
// slot_round_ctrl
// Round sequencer for the slot machine: accepts a spin, latches the bet,
// spins four reels, stops them one at a time, then emits a one-cycle settle
// strobe carrying the bet code and the win flag, followed by a hold period.
//
// Parameters: SPIN_TICKS, STOP_TICKS, HOLD_TICKS (1..255), LFSR_SEED (nonzero)
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   tick                  : pacing enable for reel motion and all tick counts
//   btn_spin              : one-cycle spin request
//   b1, b10, b50, b100    : bet switches (priority b100 > b50 > b10 > b1)
//   balance               : bank balance, compared against the decoded bet
//   reel0..reel3          : reel digits 0..9
//   busy                  : high whenever a round is in progress
//   settle                : one-cycle result strobe
//   win                   : all reels equal, valid with settle
//   bet_sel               : one-hot bet code, nonzero only with settle
//   bet_amt               : bet value latched at the last accepted spin
//   reject                : one-cycle pulse for a refused spin request
//
// Build option: define SLOT_ATTRACT_EN to keep the reels animating on every
// tick while IDLE; otherwise reels hold their last values in IDLE.
//
// Request/response: btn_spin is a single-cycle request with no ready; it is
// only looked at in IDLE. The cycle after it either busy rises (accepted) or
// reject pulses for one cycle (refused). Requests outside IDLE are dropped.
// -----------------------------------------------------------------------------
module slot_round_ctrl
    import slot_pkg::*;
#(
    parameter int          SPIN_TICKS = 8,
    parameter int          STOP_TICKS = 2,
    parameter int          HOLD_TICKS = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             btn_spin,
    input  logic             b1,
    input  logic             b10,
    input  logic             b50,
    input  logic             b100,
    input  logic [BAL_W-1:0] balance,
    output logic [3:0]       reel0,
    output logic [3:0]       reel1,
    output logic [3:0]       reel2,
    output logic [3:0]       reel3,
    output logic             busy,
    output logic             settle,
    output logic             win,
    output logic [3:0]       bet_sel,
    output logic [6:0]       bet_amt,
    output logic             reject
);

    localparam logic [7:0] SPIN_LAST = 8'(SPIN_TICKS - 1);
    localparam logic [7:0] STOP_LAST = 8'(STOP_TICKS - 1);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_TICKS - 1);

    state_e            state_q, state_d;
    logic [7:0]        tcnt_q, tcnt_d;
    logic [1:0]        stop_idx_q, stop_idx_d;   // next reel to freeze
    logic [3:0][3:0]   reel_q, reel_d;
    bet_code_t         code_q, code_d;
    logic [AMT_W-1:0]  bet_amt_q, bet_amt_d;
    logic              busy_q, busy_d;
    logic              settle_q, settle_d;
    logic              win_q, win_d;
    logic [3:0]        bet_sel_q, bet_sel_d;
    logic              reject_q, reject_d;

    logic [15:0]       lfsr;
    bet_code_t         dec_code;
    logic [AMT_W-1:0]  dec_amt;
    logic              accept_ok;
    logic              freeze_now;

    slot_lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .q    (lfsr)
    );

    // Bet decode with priority b100 > b50 > b10 > b1.
    always_comb begin
        dec_code = CODE_NONE;
        dec_amt  = '0;
        if (b100) begin
            dec_code = CODE_100;
            dec_amt  = BET_100;
        end else if (b50) begin
            dec_code = CODE_50;
            dec_amt  = BET_50;
        end else if (b10) begin
            dec_code = CODE_10;
            dec_amt  = BET_10;
        end else if (b1) begin
            dec_code = CODE_1;
            dec_amt  = BET_1;
        end
    end

    assign accept_ok = (dec_code != CODE_NONE) && (balance >= BAL_W'(dec_amt));

    // Entering STOP preloads the counter with STOP_LAST so the very first
    // tick in STOP freezes reel0; later freezes are STOP_TICKS ticks apart.
    assign freeze_now = (state_q == ST_STOP) && tick && (tcnt_q == STOP_LAST);

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tcnt_q     <= '0;
            stop_idx_q <= '0;
            reel_q     <= '0;
            code_q     <= CODE_NONE;
            bet_amt_q  <= '0;
            busy_q     <= 1'b0;
            settle_q   <= 1'b0;
            win_q      <= 1'b0;
            bet_sel_q  <= '0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tcnt_q     <= tcnt_d;
            stop_idx_q <= stop_idx_d;
            reel_q     <= reel_d;
            code_q     <= code_d;
            bet_amt_q  <= bet_amt_d;
            busy_q     <= busy_d;
            settle_q   <= settle_d;
            win_q      <= win_d;
            bet_sel_q  <= bet_sel_d;
            reject_q   <= reject_d;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        state_d    = state_q;
        tcnt_d     = tcnt_q;
        stop_idx_d = stop_idx_q;
        code_d     = code_q;
        bet_amt_d  = bet_amt_q;
        case (state_q)
            ST_IDLE: begin
                // A tick in the acceptance cycle is not counted: tcnt starts at 0.
                if (btn_spin && accept_ok) begin
                    state_d    = ST_SPIN;
                    tcnt_d     = '0;
                    stop_idx_d = '0;
                    code_d     = dec_code;
                    bet_amt_d  = dec_amt;
                end
            end
            ST_SPIN: begin
                if (tick) begin
                    if (tcnt_q == SPIN_LAST) begin
                        state_d = ST_STOP;
                        tcnt_d  = STOP_LAST;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (freeze_now) begin
                        tcnt_d     = '0;
                        stop_idx_d = stop_idx_q + 2'd1;
                        if (stop_idx_q == 2'd3) begin
                            state_d = ST_SETTLE;
                        end
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            ST_SETTLE: begin
                state_d = ST_HOLD;
                tcnt_d  = '0;
            end
            ST_HOLD: begin
                if (tick) begin
                    if (tcnt_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------ outputs
    always_comb begin
        reel_d = reel_q;
        for (int i = 0; i < 4; i++) begin
            case (state_q)
                ST_IDLE: begin
`ifdef SLOT_ATTRACT_EN
                    if (tick) begin
                        reel_d[i] = fold_digit(lfsr[4*i +: 4]);
                    end
`endif
                end
                ST_SPIN: begin
                    if (tick) begin
                        reel_d[i] = fold_digit(lfsr[4*i +: 4]);
                    end
                end
                ST_STOP: begin
                    // Reels above the stop index still spin; the indexed reel
                    // spins too unless this tick is the one that freezes it.
                    if (tick && ((int'(stop_idx_q) < i) ||
                                 ((int'(stop_idx_q) == i) && !freeze_now))) begin
                        reel_d[i] = fold_digit(lfsr[4*i +: 4]);
                    end
                end
                default: begin
                end
            endcase
        end

        busy_d    = (state_d != ST_IDLE);
        settle_d  = (state_d == ST_SETTLE);
        win_d     = settle_d && (reel_d[0] == reel_d[1]) &&
                    (reel_d[1] == reel_d[2]) && (reel_d[2] == reel_d[3]);
        bet_sel_d = settle_d ? code_d : CODE_NONE;
        reject_d  = (state_q == ST_IDLE) && btn_spin && !accept_ok;
    end

    assign reel0   = reel_q[0];
    assign reel1   = reel_q[1];
    assign reel2   = reel_q[2];
    assign reel3   = reel_q[3];
    assign busy    = busy_q;
    assign settle  = settle_q;
    assign win     = win_q;
    assign bet_sel = bet_sel_q;
    assign bet_amt = bet_amt_q;
    assign reject  = reject_q;

endmodule

// File: tb/tb_slot_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_slot_round_ctrl
// Three instances of slot_round_ctrl share one stimulus stream and differ only
// in LFSR_SEED: the default seed, a seed that lines up four zero digits at the
// freeze points of a round started right after reset with tick held high, and
// the same seed with bit 0 flipped. A reference model built from the round's
// tick schedule predicts every output of every instance each cycle.
// -----------------------------------------------------------------------------
module tb_slot_round_ctrl;

    localparam int SPIN_T = 8;
    localparam int STOP_T = 2;
    localparam int HOLD_T = 4;
    localparam int VW     = 31;   // per-instance output vector width

`ifdef SLOT_ATTRACT_EN
    localparam bit ATTRACT = 1'b1;
`else
    localparam bit ATTRACT = 1'b0;
`endif

    // Step an LFSR state backwards n clocks.
    function automatic logic [15:0] rewind(input logic [15:0] s, input int n);
        logic [15:0] q;
        q = s;
        for (int j = 0; j < n; j++) begin
            q = {q[0] ^ q[14] ^ q[13] ^ q[11], q[15:1]};
        end
        return q;
    endfunction

    // After 8 clocks this seed has bits [9:0] = 0, which are exactly the bits
    // that end up as the four frozen nibbles in the directed win round.
    localparam logic [15:0] SEED_W = rewind(16'hFC00, 8);
    localparam logic [15:0] SEED_L = SEED_W ^ 16'h0001;

    function automatic logic [15:0] seed_of(input int g);
        case (g)
            0:       return 16'hACE1;
            1:       return SEED_W;
            default: return SEED_L;
        endcase
    endfunction

    // ------------------------------------------------------------ clock/reset
    logic        clk;
    logic        rst;
    logic        tick;
    logic        btn_spin;
    logic        b1, b10, b50, b100;
    logic [26:0] balance;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [3:0] o_r0 [3];
    logic [3:0] o_r1 [3];
    logic [3:0] o_r2 [3];
    logic [3:0] o_r3 [3];
    logic       o_busy [3];
    logic       o_settle [3];
    logic       o_win [3];
    logic [3:0] o_sel [3];
    logic [6:0] o_amt [3];
    logic       o_reject [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        slot_round_ctrl #(
            .SPIN_TICKS (SPIN_T),
            .STOP_TICKS (STOP_T),
            .HOLD_TICKS (HOLD_T),
            .LFSR_SEED  (seed_of(g))
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .tick     (tick),
            .btn_spin (btn_spin),
            .b1       (b1),
            .b10      (b10),
            .b50      (b50),
            .b100     (b100),
            .balance  (balance),
            .reel0    (o_r0[g]),
            .reel1    (o_r1[g]),
            .reel2    (o_r2[g]),
            .reel3    (o_r3[g]),
            .busy     (o_busy[g]),
            .settle   (o_settle[g]),
            .win      (o_win[g]),
            .bet_sel  (o_sel[g]),
            .bet_amt  (o_amt[g]),
            .reject   (o_reject[g])
        );
    end

    // ------------------------------------------------------------ scoreboard
    logic [3*VW-1:0] exp_q[$];
    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    int tick_mode = 0;        // 0: every 4th clk, 1: every clk, 2: random
    int settle_cnt = 0;
    logic [3:0] last_sel = '0;
    logic win_w_seen = 1'b0;
    logic win_l_seen = 1'b1;

    // Reference model: phase 0 idle, 1 reels moving, 2 settle, 3 hold.
    int         m_phase;
    int         m_k;          // ticks counted since the spin was accepted
    int         m_hold;
    logic [15:0] m_lfsr [3];
    logic [3:0]  m_reel [3][4];
    logic [3:0]  m_code;
    logic [6:0]  m_amt;
    logic        m_reject;

    function automatic int freeze_tick(input int r);
        return SPIN_T + 1 + r * STOP_T;
    endfunction

    task automatic load_reel(input int n, input int r);
        m_reel[n][r] = 4'(int'(m_lfsr[n][4*r +: 4]) % 10);
    endtask

    task automatic model_step();
        logic [3*VW-1:0] e;
        logic [3:0] dcode;
        logic [6:0] damt;
        logic s, w;
        if (rst) begin
            m_phase = 0; m_k = 0; m_hold = 0;
            m_code = '0; m_amt = '0; m_reject = 1'b0;
            for (int n = 0; n < 3; n++) begin
                m_lfsr[n] = seed_of(n);
                for (int r = 0; r < 4; r++) m_reel[n][r] = '0;
            end
        end else begin
            m_reject = 1'b0;
            case (m_phase)
                0: begin
                    if (btn_spin) begin
                        if (b100)      begin dcode = 4'b1000; damt = 7'd100; end
                        else if (b50)  begin dcode = 4'b0100; damt = 7'd50;  end
                        else if (b10)  begin dcode = 4'b0010; damt = 7'd10;  end
                        else if (b1)   begin dcode = 4'b0001; damt = 7'd1;   end
                        else           begin dcode = 4'b0000; damt = 7'd0;   end
                        if (dcode != 0 && balance >= 27'(damt)) begin
                            m_phase = 1; m_k = 0; m_code = dcode; m_amt = damt;
                        end else begin
                            m_reject = 1'b1;
                        end
                    end
                    if (ATTRACT && tick) begin
                        for (int n = 0; n < 3; n++)
                            for (int r = 0; r < 4; r++) load_reel(n, r);
                    end
                end
                1: begin
                    if (tick) begin
                        m_k++;
                        for (int n = 0; n < 3; n++)
                            for (int r = 0; r < 4; r++)
                                if (m_k < freeze_tick(r)) load_reel(n, r);
                        if (m_k == freeze_tick(3)) m_phase = 2;
                    end
                end
                2: begin
                    m_phase = 3; m_hold = 0;
                end
                default: begin
                    if (tick) begin
                        m_hold++;
                        if (m_hold == HOLD_T) m_phase = 0;
                    end
                end
            endcase
            for (int n = 0; n < 3; n++)
                m_lfsr[n] = {m_lfsr[n][14:0],
                             m_lfsr[n][15] ^ m_lfsr[n][13] ^ m_lfsr[n][12] ^ m_lfsr[n][10]};
        end
        s = (m_phase == 2);
        for (int n = 0; n < 3; n++) begin
            w = s && (m_reel[n][0] == m_reel[n][1]) && (m_reel[n][0] == m_reel[n][2]) &&
                (m_reel[n][0] == m_reel[n][3]);
            e[VW*n +: VW] = {(m_phase != 0), s, w, m_reject, (s ? m_code : 4'b0000), m_amt,
                             m_reel[n][3], m_reel[n][2], m_reel[n][1], m_reel[n][0]};
        end
        exp_q.push_back(e);
    endtask

    function automatic logic [VW-1:0] observed(input int n);
        return {o_busy[n], o_settle[n], o_win[n], o_reject[n], o_sel[n], o_amt[n],
                o_r3[n], o_r2[n], o_r1[n], o_r0[n]};
    endfunction

    task automatic check_cycle();
        logic [3*VW-1:0] e;
        logic [VW-1:0] ob;
        e = exp_q.pop_front();
        for (int n = 0; n < 3; n++) begin
            ob = observed(n);
            n_vec++;
            assert (ob === e[VW*n +: VW]) else begin
                n_bad++;
                $error("FAIL inst%0d_cyc%0d observed=%h expected=%h", n, cyc, ob, e[VW*n +: VW]);
            end
        end
        if (o_settle[0]) begin
            settle_cnt++;
            last_sel = o_sel[0];
        end
        if (o_settle[1]) win_w_seen = o_win[1];
        if (o_settle[2]) win_l_seen = o_win[2];
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- drivers
    task automatic cycle();
        case (tick_mode)
            0:       tick = (cyc % 4 == 0);
            1:       tick = 1'b1;
            default: tick = 1'($urandom_range(0, 1));
        endcase
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
        cyc++;
        btn_spin = 1'b0;
    endtask

    task automatic press();
        btn_spin = 1'b1;
        cycle();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_rand(input int n);
        repeat (n) begin
            if ($urandom_range(0, 15) == 0) btn_spin = 1'b1;
            cycle();
        end
    endtask

    task automatic wait_phase(input string tag, input int ph, input int limit);
        int c;
        c = 0;
        while (m_phase != ph && c < limit) begin
            cycle();
            c++;
        end
        chk(tag, 32'(m_phase == ph), 32'd1);
    endtask

    // --------------------------------------------------------------- sequence
    initial begin
        logic [15:0] snap;
        int c;
        rst = 1'b1; tick = 1'b0; btn_spin = 1'b0;
        b1 = 1'b0; b10 = 1'b0; b50 = 1'b0; b100 = 1'b0; balance = '0;

        run(2);
        rst = 1'b0;

        // Basic round with b10 and enough balance.
        b10 = 1'b1; balance = 27'd100; settle_cnt = 0;
        press();
        chk("A_busy_next", 32'(o_busy[0]), 32'd1);
        wait_phase("A_round_done", 0, 300);
        chk("A_one_settle", 32'(settle_cnt), 32'd1);
        chk("A_bet_sel", 32'(last_sel), 32'b0010);
        chk("A_bet_amt", 32'(o_amt[0]), 32'd10);

        // b100 wins priority over b1 and exceeds the balance.
        b10 = 1'b0; b100 = 1'b1; b1 = 1'b1; balance = 27'd50;
        press();
        chk("B_reject", 32'(o_reject[0]), 32'd1);
        chk("B_busy", 32'(o_busy[0]), 32'd0);
        cycle();
        chk("B_reject_one_cycle", 32'(o_reject[0]), 32'd0);

        // Seeded win / lose round immediately after reset, tick held high.
        b100 = 1'b0; b1 = 1'b0; b10 = 1'b1; balance = 27'd100;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        tick_mode = 1;
        win_w_seen = 1'b0; win_l_seen = 1'b1;
        press();
        wait_phase("C_round_done", 0, 100);
        chk("C_win_seed", 32'(win_w_seen), 32'd1);
        chk("C_lose_seed", 32'(win_l_seen), 32'd0);

        // Spin requests during SPIN and HOLD are ignored.
        tick_mode = 0; settle_cnt = 0; b50 = 1'b1; balance = 27'd1000;
        press();
        run(12);
        press();
        wait_phase("D_reach_hold", 3, 300);
        press();
        wait_phase("D_round_done", 0, 300);
        chk("D_one_settle", 32'(settle_cnt), 32'd1);

        // Reset during STOP with reel1 already frozen aborts the round.
        settle_cnt = 0;
        press();
        c = 0;
        while (!(m_phase == 1 && m_k == freeze_tick(1) + 1) && c < 300) begin
            cycle();
            c++;
        end
        chk("E_reach_stop", 32'(m_phase == 1 && m_k == freeze_tick(1) + 1), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("E_busy", 32'(o_busy[0]), 32'd0);
        chk("E_reels", 32'({o_r3[0], o_r2[0], o_r1[0], o_r0[0]}), 32'd0);
        run(120);
        chk("E_no_settle", 32'(settle_cnt), 32'd0);

        // Ten ticks in IDLE: reels move only in the attract build.
        snap = {o_r3[0], o_r2[0], o_r1[0], o_r0[0]};
        run(40);
        chk("F_idle_reels_moved", 32'(snap != {o_r3[0], o_r2[0], o_r1[0], o_r0[0]}),
            32'(ATTRACT));

        // Randomised bets, balances, ticks and spin requests.
        tick_mode = 2;
        for (int it = 0; it < 25; it++) begin
            b1   = 1'($urandom_range(0, 1));
            b10  = 1'($urandom_range(0, 1));
            b50  = 1'($urandom_range(0, 1));
            b100 = 1'($urandom_range(0, 1));
            balance = 27'($urandom_range(0, 120));
            press();
            run_rand($urandom_range(20, 160));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/slot_round_ctrl.md
# slot_round_ctrl

Round sequencer for the slot-machine game. It accepts a spin request and latches the bet from the bet switches. It animates and then stops the four reels one at a time, and finally issues a single-cycle settle strobe with the bet code and the win flag. The bank that owns the player balance acts on that strobe, so the balance changes exactly once per round and never while the reels are moving.

## Interface
Parameters:
- SPIN_TICKS, 8: ticks spent with all reels spinning before the first stop
- STOP_TICKS, 2: ticks between successive reel stops
- HOLD_TICKS, 4: ticks the result is held after settle
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- tick  in  1  one-cycle enable pulse that paces the reels
- btn_spin  in  1  one-cycle spin request, already debounced
- b1, b10, b50, b100  in  1 each  bet switches
- balance  in  27  current bank balance
- reel0..reel3  out  4 each  reel digits, 0–9
- busy  out  1  high in every state except IDLE
- settle  out  1  one-cycle result strobe
- win  out  1  all four reels equal; valid while settle is high
- bet_sel  out  4  one-hot {b100,b50,b10,b1}; nonzero only while settle is high
- bet_amt  out  7  latched bet value: 1, 10, 50 or 100
- reject  out  1  one-cycle pulse when a spin request is refused

## Operation
- States: IDLE, SPIN, STOP, SETTLE, HOLD.
- Bet decode in IDLE uses the priority b100 > b50 > b10 > b1.
- Spin acceptance, checked in IDLE when btn_spin=1:
  - The request is accepted only if a bet switch is set and balance ≥ the decoded bet.
  - On acceptance: latch bet_amt and the one-hot code, clear the tick counter, go to SPIN.
  - Otherwise pulse reject and stay in IDLE.
- btn_spin is ignored in every state other than IDLE.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clk regardless of state.
- Reel update: on each tick, every reel not yet stopped loads a new digit.
  - Reel i takes LFSR nibble i (reel0 takes bits [3:0]).
  - Fold rule: nibble ≥ 10 → nibble − 10, else the nibble unchanged.
- SPIN → STOP after SPIN_TICKS ticks.
- In STOP:
  - reel0 freezes on the first tick in STOP.
  - reel1, reel2 and reel3 each freeze STOP_TICKS ticks after the previous reel.
  - A frozen reel keeps its value until the next accepted spin.
- STOP → SETTLE on the cycle after reel3 freezes.
- SETTLE lasts exactly one cycle:
  - settle=1.
  - win = (reel0==reel1==reel2==reel3).
  - bet_sel = the latched one-hot code.
- SETTLE → HOLD.
- HOLD → IDLE after HOLD_TICKS ticks. Reels stay frozen during HOLD.
- Counters are sized for parameters up to 255.
- A tick arriving in the same cycle as btn_spin in IDLE does not count toward SPIN_TICKS.

## Timing
- Reset values:
  - state IDLE, all reels 0, LFSR = LFSR_SEED.
  - busy, settle, win, reject all 0; bet_sel = 0; bet_amt = 0.
- All outputs are registered.
- Accepted spin: busy rises the cycle after the btn_spin cycle. reject is never asserted for an accepted spin.
- Refused spin: reject is high the cycle after btn_spin, for exactly one cycle.
- Minimum round length in ticks: SPIN_TICKS + 1 + 3·STOP_TICKS + HOLD_TICKS, plus 1 clk for SETTLE.
- settle is high for exactly one clk per accepted spin.
- If tick is held constantly high, every clk counts as a tick.
- Reset asserted mid-round aborts the round:
  - no settle is produced;
  - outputs return to their reset values on the next edge.
- The bank must sample bet_sel and win only while settle is high.

## Configuration
- SLOT_ATTRACT_EN defined: reels keep loading folded LFSR digits on every tick while in IDLE (attract animation). On an accepted spin the reels continue from their current values.
- SLOT_ATTRACT_EN undefined: reels hold their last values in IDLE, or 0 after reset.
- State transitions, settle timing and the bet logic are identical in both builds.

## Structure
- Shared package slot_pkg holds:
  - the state enum;
  - bet constants BET_1/10/50/100;
  - the one-hot bet code typedef;
  - BAL_W = 27.
- Sub-module slot_lfsr16: ports clk, rst, seed; output q[15:0]. It contains the free-running LFSR with synchronous reload to the seed on reset.
- The top level holds the FSM, the tick counter, the reel-stop index, the bet latch and the digit fold.

## Test plan
- Reset, then spin with b10=1 and balance=100, SPIN_TICKS=8, STOP_TICKS=2, HOLD_TICKS=4, tick every 4 clks → busy the next cycle; reels frozen in order 0,1,2,3 at 2-tick spacing; one settle with bet_sel=4'b0010 and bet_amt=10; IDLE after 4 further ticks.
- b100=1 and b1=1 together with balance=50 → reject=1 for one cycle, busy stays 0 (bet decodes to 100, which exceeds the balance).
- Force the LFSR via seed so that all four folded digits match at their freeze points → win=1 during settle; change one seed bit → win=0.
- btn_spin pulsed during SPIN and during HOLD → no effect; exactly one settle for the round.
- rst asserted during STOP after reel1 has frozen → next edge gives IDLE, reels=0, busy=0, and no settle at any later point.
- Build with and without SLOT_ATTRACT_EN, 10 ticks in IDLE → reels change only in the SLOT_ATTRACT_EN build.
